stream_response_checker: RTL and testbench

- Synthesizable receive-side checker for DUT output streams in the CNN datapath benches and on-board self-test.
- Accepts a valid/ready stream of NUM_BEATS words and compares each word against an expected incrementing sequence (seed + index).
- Reports pass/fail, error count, the first mismatching beat, and a no-activity timeout.
- Sits downstream of the DUT, opposite the stimulus driver.

---
 rtl/chk_pkg.sv | 23 ++
 rtl/cycle_timer.sv | 49 ++++
 rtl/stream_response_checker.sv | 208 ++++++++++++++++++++
 tb/tb_stream_response_checker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/chk_pkg.sv
// Shared definitions for the stream checker blocks: state encodings and
// the counter-width helper used to size beat, error and timer counters.
package chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable inactivity counter. Counts enabled cycles up to LIMIT-1 and
// holds there; expire_o is high while the count sits at LIMIT-1.
// Clear has priority over load, load over counting.
module cycle_timer
    import chk_pkg::*;
#(
    parameter int LIMIT = 64,
    parameter int W     = cnt_width(LIMIT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, load, or advance while below the expiry value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/stream_response_checker.sv
// Receive-side stream checker: accepts NUM_BEATS words over valid/ready and
// compares each against seed + beat index (mod 2^DATA_W). Reports pass,
// saturating error count, first mismatch, and an inactivity timeout.
// Optional periodic one-cycle backpressure via STALL_EVERY.
module stream_response_checker
    import chk_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int NUM_BEATS   = 16,
    parameter int TIMEOUT     = 64,
    parameter int STALL_EVERY = 0,
    localparam int CNT_W      = cnt_width(NUM_BEATS),
    localparam int TO_W       = cnt_width(TIMEOUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_data,
    output logic              timeout
);

    localparam int SC_W      = cnt_width(STALL_EVERY);
    localparam bit STALL_EN  = (STALL_EVERY > 0);
    localparam int STALL_LIM = (STALL_EVERY > 0) ? (STALL_EVERY - 1) : 0;

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_BEATS - 1);
    localparam logic [CNT_W-1:0] ERR_MAX   = {CNT_W{1'b1}};
    localparam logic [SC_W-1:0]  STALL_TOP = SC_W'(STALL_LIM);

    state_e              state_q,   state_d;
    logic [DATA_W-1:0]   seed_q,    seed_d;
    logic [CNT_W-1:0]    beat_idx_q, beat_idx_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]    fe_idx_q,  fe_idx_d;
    logic [DATA_W-1:0]   fe_data_q, fe_data_d;
    logic                timeout_q, timeout_d;
    logic                done_q,    done_d;
    logic                pass_q,    pass_d;
    logic                busy_q,    busy_d;
    logic                ready_q,   ready_d;
    logic [SC_W-1:0]     stall_q,   stall_d;

    logic                accept_s;
    logic                launch_s;
    logic                mismatch_s;
    logic [DATA_W-1:0]   exp_data_s;
    logic                expire_s;

    assign accept_s   = s_valid && ready_q;
    assign launch_s   = start && (state_q != ST_RUN);
    assign exp_data_s = seed_q + DATA_W'(beat_idx_q);
    assign mismatch_s = accept_s && (s_data != exp_data_s);

    cycle_timer #(
        .LIMIT (TIMEOUT),
        .W     (TO_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (accept_s),
        .load_i     (launch_s),
        .load_val_i ({TO_W{1'b0}}),
        .en_i       (state_q == ST_RUN),
        .expire_o   (expire_s)
    );

    // Next-state and result computation for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d    = state_q;
        seed_d     = seed_q;
        beat_idx_d = beat_idx_q;
        err_cnt_d  = err_cnt_q;
        fe_idx_d   = fe_idx_q;
        fe_data_d  = fe_data_q;
        timeout_d  = timeout_q;
        done_d     = done_q;
        pass_d     = pass_q;
        busy_d     = busy_q;
        ready_d    = ready_q;
        stall_d    = stall_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    seed_d     = seed;
                    beat_idx_d = '0;
                    err_cnt_d  = '0;
                    fe_idx_d   = '0;
                    fe_data_d  = '0;
                    timeout_d  = 1'b0;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    busy_d     = 1'b1;
                    ready_d    = 1'b1;
                    stall_d    = '0;
                end else begin
                    ready_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    beat_idx_d = beat_idx_q + 1'b1;
                    // Error bookkeeping; first mismatch only recorded once.
                    if (mismatch_s) begin
                        if (err_cnt_q != ERR_MAX) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end else begin
                            err_cnt_d = err_cnt_q;
                        end
                        if (err_cnt_q == '0) begin
                            fe_idx_d  = beat_idx_q;
                            fe_data_d = s_data;
                        end else begin
                            fe_idx_d  = fe_idx_q;
                            fe_data_d = fe_data_q;
                        end
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                    // Final beat closes the run; otherwise decide on a stall.
                    if (beat_idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b0;
                        pass_d  = (err_cnt_d == '0);
                        stall_d = '0;
                    end else if (STALL_EN && (stall_q == STALL_TOP)) begin
                        ready_d = 1'b0;
                        stall_d = '0;
                    end else begin
                        ready_d = 1'b1;
                        stall_d = stall_q + 1'b1;
                    end
                end else if (expire_s) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    ready_d   = 1'b0;
                    pass_d    = 1'b0;
                end else begin
                    // Stall cycles last exactly one cycle.
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

    // State and result registers, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            seed_q     <= '0;
            beat_idx_q <= '0;
            err_cnt_q  <= '0;
            fe_idx_q   <= '0;
            fe_data_q  <= '0;
            timeout_q  <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            seed_q     <= seed_d;
            beat_idx_q <= beat_idx_d;
            err_cnt_q  <= err_cnt_d;
            fe_idx_q   <= fe_idx_d;
            fe_data_q  <= fe_data_d;
            timeout_q  <= timeout_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            stall_q    <= stall_d;
        end
    end

    assign s_ready        = ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_idx  = fe_idx_q;
    assign first_err_data = fe_data_q;
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_stream_response_checker.sv
// Directed bench for stream_response_checker. Two instances: A without
// stalls, B with STALL_EVERY=4. A select line routes the shared stimulus
// to one instance and muxes its outputs back for checking.
module tb_stream_response_checker;

    localparam int TO = 64;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sel = 1'b0;
    logic start = 1'b0;
    logic [7:0] seed = 8'h00;
    logic s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;

    logic a_rdy, a_busy, a_done, a_pass, a_to;
    logic b_rdy, b_busy, b_done, b_pass, b_to;
    logic [CW-1:0] a_err, a_fidx, b_err, b_fidx;
    logic [7:0] a_fdat, b_fdat;

    logic a_start, b_start, a_valid, b_valid;
    assign a_start = start & ~sel;
    assign b_start = start & sel;
    assign a_valid = s_valid & ~sel;
    assign b_valid = s_valid & sel;

    logic rdy_m, busy_m, done_m, pass_m, to_m;
    logic [CW-1:0] err_m, fidx_m;
    logic [7:0] fdat_m;
    assign rdy_m  = sel ? b_rdy  : a_rdy;
    assign busy_m = sel ? b_busy : a_busy;
    assign done_m = sel ? b_done : a_done;
    assign pass_m = sel ? b_pass : a_pass;
    assign to_m   = sel ? b_to   : a_to;
    assign err_m  = sel ? b_err  : a_err;
    assign fidx_m = sel ? b_fidx : a_fidx;
    assign fdat_m = sel ? b_fdat : a_fdat;

    always #5 clk = ~clk;

    stream_response_checker #(.DATA_W(8), .NUM_BEATS(16), .TIMEOUT(TO), .STALL_EVERY(0)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .seed(seed), .s_valid(a_valid), .s_data(s_data),
        .s_ready(a_rdy), .busy(a_busy), .done(a_done), .pass(a_pass), .err_cnt(a_err),
        .first_err_idx(a_fidx), .first_err_data(a_fdat), .timeout(a_to));

    stream_response_checker #(.DATA_W(8), .NUM_BEATS(16), .TIMEOUT(TO), .STALL_EVERY(4)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .seed(seed), .s_valid(b_valid), .s_data(s_data),
        .s_ready(b_rdy), .busy(b_busy), .done(b_done), .pass(b_pass), .err_cnt(b_err),
        .first_err_idx(b_fidx), .first_err_data(b_fdat), .timeout(b_to));

    int n_chk = 0;
    int n_pass = 0;
    int run_cycles;
    int low_beats[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s (sel=%0d): got %0h expected %0h", name, sel, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Called at a negedge; pulses start for one edge and returns at the next negedge.
    task automatic do_start(input logic [7:0] sd);
        seed = sd;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sends beats b0..n-1 with s_valid high; corrupted beats are XORed with xr.
    // Returns at the negedge right after the last accepting edge.
    task automatic drive(input logic [7:0] sd, input logic [15:0] mask, input logic [7:0] xr,
                         input int b0, input int n);
        int b;
        int guard;
        logic r;
        b = b0;
        guard = 0;
        run_cycles = 0;
        low_beats.delete();
        while (b < n && guard < 400) begin
            s_valid = 1'b1;
            s_data  = (sd + 8'(b)) ^ (mask[b] ? xr : 8'h00);
            r = rdy_m;
            run_cycles++;
            if (!r) low_beats.push_back(b);
            @(posedge clk);
            if (r) b++;
            @(negedge clk);
            guard++;
        end
        s_valid = 1'b0;
        check("beats_accepted", b, n);
    endtask

    typedef struct {
        logic [7:0]  sd;
        logic [15:0] mask;
        logic [7:0]  xr;
        int          err;
        int          fidx;
        logic [7:0]  fdat;
        logic        pas;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'h10, 16'h0000, 8'h00, 0,  0,  8'h00, 1'b1}; // clean
        vecs[1] = '{8'h10, 16'h0020, 8'hBF, 1,  5,  8'hAA, 1'b0}; // beat5 15->AA
        vecs[2] = '{8'hFE, 16'h0204, 8'h55, 2,  2,  8'h55, 1'b0}; // wrap, beats 2,9
        vecs[3] = '{8'hF0, 16'hFFFF, 8'h01, 16, 0,  8'hF1, 1'b0}; // all beats bad
        vecs[4] = '{8'h20, 16'h8000, 8'h80, 1,  15, 8'hAF, 1'b0}; // last beat bad

        // Reset state
        #12;
        for (int u = 0; u < 2; u++) begin
            sel = u[0];
            #1;
            check("rst_ready", rdy_m, 0);
            check("rst_busy", busy_m, 0);
            check("rst_done", done_m, 0);
            check("rst_pass", pass_m, 0);
            check("rst_err", err_m, 0);
            check("rst_to", to_m, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Table-driven full runs on both instances
        for (int u = 0; u < 2; u++) begin
            sel = u[0];
            for (int i = 0; i < 5; i++) begin
                do_start(vecs[i].sd);
                check("start_busy", busy_m, 1);
                check("start_ready", rdy_m, 1);
                drive(vecs[i].sd, vecs[i].mask, vecs[i].xr, 0, 16);
                check("done_latency", done_m, 1);
                check("done_busy", busy_m, 0);
                check("done_ready", rdy_m, 0);
                check("pass", pass_m, vecs[i].pas);
                check("err_cnt", err_m, vecs[i].err);
                check("first_idx", fidx_m, vecs[i].fidx);
                check("first_data", fdat_m, vecs[i].fdat);
                check("timeout", to_m, 0);
                if (u == 0) check("run_cycles_nostall", run_cycles, 16);
                repeat (3) @(negedge clk);
                check("done_held", done_m, 1);
                check("err_held", err_m, vecs[i].err);
            end
        end

        // Stall pattern on B
        sel = 1'b1;
        do_start(8'h40);
        drive(8'h40, 16'h0000, 8'h00, 0, 16);
        check("stall_cycles", run_cycles, 19);
        check("stall_lows", low_beats.size(), 3);
        for (int i = 0; i < low_beats.size() && i < 3; i++) begin
            check("stall_pos", low_beats[i], 4 * (i + 1));
        end
        check("stall_pass", pass_m, 1);
        check("stall_err", err_m, 0);

        // Timeout on A: 3 beats then silence
        sel = 1'b0;
        begin
            int k;
            do_start(8'h30);
            drive(8'h30, 16'h0000, 8'h00, 0, 3);
            k = 0;
            check("to_early", to_m, 0);
            while (!to_m && k < 200) begin
                @(posedge clk);
                k++;
                @(negedge clk);
            end
            check("to_delay", k, TO);
            check("to_flag", to_m, 1);
            check("to_done", done_m, 1);
            check("to_pass", pass_m, 0);
            check("to_err", err_m, 0);
            check("to_busy", busy_m, 0);
        end

        // Ignored start during RUN, then async reset mid-run
        do_start(8'h50);
        drive(8'h50, 16'h0000, 8'h00, 0, 3);
        seed = 8'h99;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("ign_start_busy", busy_m, 1);
        drive(8'h50, 16'h0000, 8'h00, 3, 7);
        check("ign_start_err", err_m, 0);
        check("ign_start_done", done_m, 0);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", busy_m, 0);
        check("arst_ready", rdy_m, 0);
        check("arst_err", err_m, 0);
        check("arst_done", done_m, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_start(8'h60);
        drive(8'h60, 16'h0000, 8'h00, 0, 16);
        check("post_rst_done", done_m, 1);
        check("post_rst_pass", pass_m, 1);
        check("post_rst_err", err_m, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
